// File: rtl/syn_branch_predictor_pkg.sv
// Shared definitions for the branch predictor.
// Contents:
//   ImAddrBit  - default instruction-memory word-address width
//   sat_cnt_e  - 2-bit saturating counter encodings
//   idx_bits() - index width for a given entry count
package syn_branch_predictor_pkg;

    localparam int unsigned ImAddrBit = 12;

    typedef enum logic [1:0] {
        CntSnt = 2'd0,  // strongly not taken
        CntWnt = 2'd1,  // weakly not taken
        CntWt  = 2'd2,  // weakly taken
        CntSt  = 2'd3   // strongly taken
    } sat_cnt_e;

    function automatic int unsigned idx_bits(input int unsigned entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/cmb_sat_counter2.sv
// Combinational next-state function for a 2-bit saturating counter.
// Ports:
//   cnt      - current counter value
//   taken    - branch outcome (1 = count up, 0 = count down)
//   cnt_next - next counter value, saturating at CntSnt / CntSt
module cmb_sat_counter2
    import syn_branch_predictor_pkg::*;
(
    input  sat_cnt_e cnt,
    input  logic     taken,
    output sat_cnt_e cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != CntSt) cnt_next = sat_cnt_e'(cnt + 2'd1);
        end else begin
            if (cnt != CntSnt) cnt_next = sat_cnt_e'(cnt - 2'd1);
        end
    end

endmodule

// File: rtl/syn_branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   en              - global enable; low freezes all state
//   pc              - IF fetch word address
//   pred_taken      - predicted taken for the instruction at pc
//   pred_target     - predicted next word address (pc+1 when not taken)
//   upd_valid       - a conditional branch resolves in EX this cycle
//   upd_pc          - word address of the resolving branch
//   upd_pred        - prediction that travelled with the branch
//   upd_taken       - actual outcome
//   upd_target      - actual taken target
//   mispredict      - combinational mispredict flag for the resolving branch
//   branch_cnt      - resolved-branch count
//   miss_cnt        - mispredict count
module syn_branch_predictor
    import syn_branch_predictor_pkg::*;
#(
    parameter int unsigned Entries = 16,
    parameter int unsigned AddrBit = ImAddrBit
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [AddrBit-1:0] pc,
    output logic               pred_taken,
    output logic [AddrBit-1:0] pred_target,
    input  logic               upd_valid,
    input  logic [AddrBit-1:0] upd_pc,
    input  logic               upd_pred,
    input  logic               upd_taken,
    input  logic [AddrBit-1:0] upd_target,
    output logic               mispredict,
    output logic [31:0]        branch_cnt,
    output logic [31:0]        miss_cnt
);

    localparam int unsigned IdxBit = idx_bits(Entries);
    localparam int unsigned TagBit = AddrBit - IdxBit;

    logic [Entries-1:0] valid_q;
    logic [TagBit-1:0]  tag_q    [Entries];
    logic [AddrBit-1:0] target_q [Entries];
    sat_cnt_e           cnt_q    [Entries];
    logic [31:0]        branch_cnt_q;
    logic [31:0]        miss_cnt_q;

    logic [IdxBit-1:0]  lk_idx;
    logic [TagBit-1:0]  lk_tag;
    logic               lk_hit;
    logic [IdxBit-1:0]  up_idx;
    logic [TagBit-1:0]  up_tag;
    logic               up_hit;
    sat_cnt_e           up_cnt_next;

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    always_comb begin
        lk_idx      = pc[IdxBit-1:0];
        lk_tag      = pc[AddrBit-1:IdxBit];
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken  = lk_hit && cnt_q[lk_idx][1];
        pred_target = pred_taken ? target_q[lk_idx] : pc + AddrBit'(1);
    end

    always_comb begin
        up_idx     = upd_pc[IdxBit-1:0];
        up_tag     = upd_pc[AddrBit-1:IdxBit];
        up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        // Evaluated regardless of en so the pipeline can still flush.
        mispredict = upd_valid &&
                     ((upd_pred != upd_taken) || (upd_pred && (target_q[up_idx] != upd_target)));
    end

    cmb_sat_counter2 u_sat_counter (
        .cnt      (cnt_q[up_idx]),
        .taken    (upd_taken),
        .cnt_next (up_cnt_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= '0;
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
            for (int unsigned i = 0; i < Entries; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CntSnt;
            end
        end else if (en && upd_valid) begin
            branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mispredict) miss_cnt_q <= miss_cnt_q + 32'd1;
            if (up_hit) begin
                cnt_q[up_idx] <= up_cnt_next;
                if (upd_taken) target_q[up_idx] <= upd_target;
            end else if (upd_taken) begin
                // Allocate or replace the aliasing entry, starting weakly taken.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                cnt_q[up_idx]    <= CntWt;
            end
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_syn_branch_predictor.sv
module tb_syn_branch_predictor;

    localparam int unsigned Entries = 16;
    localparam int unsigned AddrBit = 12;
    localparam int unsigned AddrMod = 4096;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic [AddrBit-1:0] pc;
    logic               pred_taken;
    logic [AddrBit-1:0] pred_target;
    logic               upd_valid;
    logic [AddrBit-1:0] upd_pc;
    logic               upd_pred;
    logic               upd_taken;
    logic [AddrBit-1:0] upd_target;
    logic               mispredict;
    logic [31:0]        branch_cnt;
    logic [31:0]        miss_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: plain integer table indexed by address modulo Entries.
    bit          m_valid  [Entries];
    int unsigned m_tag    [Entries];
    int unsigned m_target [Entries];
    int unsigned m_cnt    [Entries];
    int unsigned m_branch;
    int unsigned m_miss;

    always #5 clk = ~clk;

    syn_branch_predictor #(
        .Entries (Entries),
        .AddrBit (AddrBit)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .pc          (pc),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_pred    (upd_pred),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .mispredict  (mispredict),
        .branch_cnt  (branch_cnt),
        .miss_cnt    (miss_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < int'(Entries); i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 0;
            m_cnt[i]    = 0;
        end
        m_branch = 0;
        m_miss   = 0;
    endfunction

    function automatic bit m_hit(input int unsigned a);
        return m_valid[a % Entries] && (m_tag[a % Entries] == a / Entries);
    endfunction

    function automatic bit m_taken(input int unsigned a);
        return m_hit(a) && (m_cnt[a % Entries] >= 2);
    endfunction

    function automatic int unsigned m_next(input int unsigned a);
        return m_taken(a) ? m_target[a % Entries] : (a + 1) % AddrMod;
    endfunction

    function automatic bit m_mispredict(input bit uv, input int unsigned up, input bit upr,
                                        input bit ut, input int unsigned utg);
        return uv && ((upr != ut) || (upr && (m_target[up % Entries] != utg)));
    endfunction

    function automatic void m_update(input bit e, input bit uv, input int unsigned up,
                                     input bit upr, input bit ut, input int unsigned utg);
        int unsigned idx;
        if (!(e && uv)) return;
        idx = up % Entries;
        m_branch++;
        if (m_mispredict(uv, up, upr, ut, utg)) m_miss++;
        if (m_hit(up)) begin
            if (ut) begin
                m_cnt[idx]    = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
                m_target[idx] = utg;
            end else begin
                m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
            end
        end else if (ut) begin
            m_valid[idx]  = 1'b1;
            m_tag[idx]    = up / Entries;
            m_target[idx] = utg;
            m_cnt[idx]    = 2;
        end
    endfunction

    // One cycle: drive, check lookup/mispredict before the edge, then counters after it.
    task automatic step(input bit e, input int unsigned p, input bit uv, input int unsigned up,
                        input bit upr, input bit ut, input int unsigned utg);
        en         = e;
        pc         = AddrBit'(p);
        upd_valid  = uv;
        upd_pc     = AddrBit'(up);
        upd_pred   = upr;
        upd_taken  = ut;
        upd_target = AddrBit'(utg);
        #1;
        check("pred_taken", 32'(pred_taken), 32'(m_taken(p)));
        check("pred_target", 32'(pred_target), m_next(p));
        check("mispredict", 32'(mispredict), 32'(m_mispredict(uv, up, upr, ut, utg)));
        @(posedge clk);
        m_update(e, uv, up, upr, ut, utg);
        #1;
        check("branch_cnt", branch_cnt, m_branch);
        check("miss_cnt", miss_cnt, m_miss);
    endtask

    // Reset raised mid-cycle with the current inputs still applied.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check("rst_pred_taken", 32'(pred_taken), 32'd0);
        check("rst_pred_target", 32'(pred_target), (32'(pc) + 1) % AddrMod);
        check("rst_branch_cnt", branch_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int unsigned a;
        int unsigned ua;
        int unsigned tg;
        bit          tk;
        bit          pr;
        bit          e;

        rst        = 1'b1;
        en         = 1'b0;
        pc         = 12'h010;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_pred   = 1'b0;
        upd_taken  = 1'b0;
        upd_target = '0;
        m_reset();
        #3;
        check("reset_pred_taken", 32'(pred_taken), 32'd0);
        check("reset_pred_target", 32'(pred_target), 32'h011);
        check("reset_branch_cnt", branch_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold lookup, then first taken update allocates.
        step(1, 'h010, 0, 'h000, 0, 0, 'h000);
        check("cold_target", 32'(pred_target), 32'h011);
        en = 1'b1; pc = 12'h010; upd_valid = 1'b1; upd_pc = 12'h010;
        upd_pred = 1'b0; upd_taken = 1'b1; upd_target = 12'h040;
        #1;
        check("first_mispredict", 32'(mispredict), 32'd1);
        @(posedge clk);
        m_update(1, 1, 'h010, 0, 1, 'h040);
        #1;
        check("alloc_pred_taken", 32'(pred_taken), 32'd1);
        check("alloc_pred_target", 32'(pred_target), 32'h040);
        check("alloc_miss_cnt", miss_cnt, 32'd1);

        // Saturate up, then walk down.
        for (int i = 0; i < 4; i++) step(1, 'h010, 1, 'h010, 1, 1, 'h040);
        step(1, 'h010, 1, 'h010, 1, 0, 'h040);
        check("sat_still_taken", 32'(pred_taken), 32'd1);
        step(1, 'h010, 1, 'h010, 1, 0, 'h040);
        check("sat_now_not_taken", 32'(pred_taken), 32'd0);
        check("sat_fallthrough", 32'(pred_target), 32'h011);

        // Alias 0x020 replaces 0x010 in the same slot.
        step(1, 'h010, 1, 'h010, 0, 1, 'h040);
        step(1, 'h020, 1, 'h020, 0, 1, 'h080);
        check("alias_new_target", 32'(pred_target), 32'h080);
        step(1, 'h010, 0, 'h000, 0, 0, 'h000);
        check("alias_old_misses", 32'(pred_taken), 32'd0);

        // Same-cycle lookup/update of 0x010: old view now, new view next cycle.
        step(1, 'h010, 1, 'h010, 0, 1, 'h044);
        check("bypass_next_cycle", 32'(pred_target), 32'h044);

        // en=0: mispredict still flagged, nothing else moves.
        step(0, 'h030, 1, 'h030, 0, 1, 'h100);
        step(1, 'h030, 0, 'h000, 0, 0, 'h000);
        check("en_off_no_alloc", 32'(pred_taken), 32'd0);

        // Reset in mid-cycle while an update is pending.
        en = 1'b1; pc = 12'h010; upd_valid = 1'b1; upd_pc = 12'h010;
        upd_pred = 1'b1; upd_taken = 1'b1; upd_target = 12'h044;
        mid_reset();
        step(1, 'h010, 0, 'h000, 0, 0, 'h000);

        // Randomized traffic over a small aliasing address pool.
        for (int n = 0; n < 600; n++) begin
            a  = ($urandom_range(0, 3) * 16 + $urandom_range(0, 3)) % AddrMod;
            ua = ($urandom_range(0, 3) * 16 + $urandom_range(0, 3)) % AddrMod;
            if ($urandom_range(0, 3) == 0) a = ua;
            case ($urandom_range(0, 2))
                0:       tg = 'h040;
                1:       tg = 'h080;
                default: tg = $urandom_range(0, AddrMod - 1);
            endcase
            tk = 1'($urandom_range(0, 1));
            pr = ($urandom_range(0, 3) != 0) ? m_taken(ua) : 1'($urandom_range(0, 1));
            e  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 149) == 0) begin
                pc = AddrBit'(a);
                mid_reset();
            end
            step(e, a, 1'($urandom_range(0, 4) != 0), ua, pr, tk, tg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/syn_branch_predictor.md
SYN_BRANCH_PREDICTOR -- requirements
Module: syn_branch_predictor

Interface
REQ-001 SHALL have parameter Entries, default 16, meaning number of predictor entries (power of two, 4..64).
REQ-002 SHALL have parameter AddrBit, default `IM_ADDR_BIT, meaning the word-address width of the program counter.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit, global enable; when low, no state changes.
REQ-006 SHALL have port pc, input, AddrBit bits, IF-stage fetch word address.
REQ-007 SHALL have port pred_taken, output, 1 bit, prediction that the instruction at pc is a taken branch.
REQ-008 SHALL have port pred_target, output, AddrBit bits, predicted next word address; equals pc+1 when pred_taken=0.
REQ-009 SHALL have port upd_valid, input, 1 bit, an EX-stage conditional branch resolves this cycle.
REQ-010 SHALL have port upd_pc, input, AddrBit bits, word address of the resolving branch.
REQ-011 SHALL have port upd_pred, input, 1 bit, pred_taken value carried down the pipeline with that branch.
REQ-012 SHALL have port upd_taken, input, 1 bit, actual branch outcome.
REQ-013 SHALL have port upd_target, input, AddrBit bits, actual taken target.
REQ-014 SHALL have port mispredict, output, 1 bit, combinational flag: upd_valid and (upd_pred != upd_taken, or upd_pred=1 and the stored target != upd_target).
REQ-015 SHALL have port branch_cnt, output, 32 bits, count of resolved branches.
REQ-016 SHALL have port miss_cnt, output, 32 bits, count of mispredictions.

Function
REQ-017 Each entry SHALL hold valid, tag (AddrBit - log2(Entries) bits), target (AddrBit bits) and a 2-bit saturating counter; direct-mapped, index = low log2(Entries) bits of the address.
REQ-018 Lookup SHALL be combinational: hit = valid and tag match; pred_taken = hit and counter[1]; pred_target = stored target if pred_taken, else pc+1, wrapping modulo 2^AddrBit.
REQ-019 On upd_valid with en high, a tag-matching entry SHALL increment its counter on taken (saturate at 3) and decrement on not-taken (saturate at 0), and load upd_target when taken.
REQ-020 On upd_valid with a miss and upd_taken=1, the entry SHALL be allocated/replaced: valid=1, new tag, target=upd_target, counter=2 (weakly taken).
REQ-021 On upd_valid with a miss and upd_taken=0, the entries SHALL remain unchanged.
REQ-022 A lookup and an update to the same index in the same cycle SHALL return the pre-update contents (no bypass); the update takes effect from the next cycle.
REQ-023 branch_cnt SHALL increment by 1 per cycle with upd_valid and en high; miss_cnt SHALL increment when mispredict is also high; both wrap modulo 2^32.
REQ-024 With en low, mispredict SHALL still be evaluated, but no entry or counter SHALL change.

Reset
REQ-025 rst high SHALL asynchronously clear all valid bits, counters, targets and tags to 0, and branch_cnt/miss_cnt to 0.
REQ-026 During and after reset with no updates: pred_taken=0, pred_target=pc+1.
REQ-027 rst asserted mid-run SHALL discard all history; the first post-reset lookup of any pc SHALL miss.

Structure
REQ-028 Entries-related widths and the counter encodings (SNT=0, WNT=1, WT=2, ST=3) SHALL be defined in Core.vh alongside the existing `IM_ADDR_BIT and `*_BIT constants.
REQ-029 A single sub-module, cmb_sat_counter2 (a 2-bit saturating next-state function), SHALL be used; the entry array SHALL be a flat register array in this module.
REQ-030 The top-level pipeline SHALL select pred_target as the next PC in IF and use mispredict to flush IF/ID and ID/EX, replacing the existing always-not-taken load_pc path.

Verification
REQ-031 Reset, then pc=0x010 -> pred_taken=0, pred_target=0x011; branch_cnt=0.
REQ-032 Update pc=0x010 with upd_pred=0, taken=1, target=0x040 -> mispredict=1; next cycle, lookup 0x010 -> pred_taken=1, pred_target=0x040; miss_cnt=1.
REQ-033 Four taken updates to 0x010, then one not-taken -> counter goes 2->3 (saturates)->2, still predicts taken; after two not-taken updates total, predicts not-taken.
REQ-034 Alias: with Entries=16, allocate 0x010, then a taken update at 0x020 -> 0x010 misses; 0x020 hits with the new target.
REQ-035 Same-cycle lookup and update of 0x010 -> the lookup shows the old prediction; the following cycle shows the new one.
REQ-036 Assert rst between two clock edges while updates are active -> all outputs are cleared immediately without waiting for a clock edge; en=0 updates -> no counter or entry change.
